branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- IF-stage producer of next-PC predictions for the 16-bit pipeline; the resolving end (ID-stage branch-condition/flush logic) checks these and sends outcomes back through the update port.
- Direct-mapped branch target buffer: tag, target and 2-bit saturating counter per entry.
- Lookup is combinational on the IF PC; training is registered on the clock edge.

Parameters:
- ENTRY_BITS, 4, log2 of entry count (16 entries); index = pc[ENTRY_BITS-1:0].
- TAG_BITS, `WORD_SIZE-ENTRY_BITS, tag = pc[`WORD_SIZE-1:ENTRY_BITS].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_IF  input  `WORD_SIZE  PC being fetched.
- pred_taken  output  1  predicted taken for pc_IF.
- pred_hit  output  1  valid entry with matching tag for pc_IF.
- pred_pc_next  output  `WORD_SIZE  predicted next PC: target if pred_taken, else pc_IF+1.
- upd_valid  input  1  resolved control-flow outcome present this cycle.
- upd_pc  input  `WORD_SIZE  PC of resolved instruction.
- upd_target  input  `WORD_SIZE  resolved target address.
- upd_taken  input  1  resolved direction.
- upd_uncond  input  1  unconditional jump (JMP/JAL/JPR/JRL); only meaningful with upd_taken=1.

Behaviour:
- Storage per entry: valid, tag[TAG_BITS], target[`WORD_SIZE], ctr[2].
- Reset (synchronous, active-high): all valid=0, all ctr=01, takes effect at the edge; mid-operation reset discards any same-cycle update.
- Outputs are purely combinational from pc_IF and stored state; with all entries invalid: pred_hit=0, pred_taken=0, pred_pc_next=pc_IF+1.
- pred_hit = valid[idx] && tag[idx]==pc_IF tag; pred_taken = pred_hit && ctr[idx][1].
- pc_IF+1 is 16-bit modular: 0xFFFF -> 0x0000.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Update when upd_valid=1 at a clock edge, on index/tag of upd_pc:
  - Miss (invalid or tag mismatch) and upd_taken=0: no change; no allocation on not-taken.
  - Miss and upd_taken=1: allocate; valid=1, tag and target written; ctr=11 if upd_uncond, else 10. Any aliased entry is overwritten.
  - Hit and upd_taken=1: ctr=11 if upd_uncond, else ctr+1 saturating at 11; target overwritten with upd_target.
  - Hit and upd_taken=0: ctr-1 saturating at 00; target unchanged.
- upd_valid=0: no state change. upd_uncond with upd_taken=0 is treated as a conditional not-taken update.
- One update per cycle. Lookup and update in the same cycle at the same index return pre-update state unless BP_FWD_EN.
- Latency: an update becomes visible to lookups in the cycle after its edge.
- No stall input: caller holds upd_valid low during stalls to avoid double training.

Optional Feature:
- Macro: BP_FWD_EN.
- Defined: same-cycle bypass. When upd_valid=1 and upd_pc==pc_IF, outputs reflect the post-update entry (new valid/tag/target/ctr) combinationally.
- Undefined: outputs always reflect registered state (one-cycle training latency).

Test Plan:
- Reset, pc_IF=0x0010 -> pred_hit=0, pred_taken=0, pred_pc_next=0x0011; pc_IF=0xFFFF -> pred_pc_next=0x0000.
- Update pc=0x0010, taken, target=0x0030, conditional; next cycle pc_IF=0x0010 -> hit=1, taken=1, next=0x0030 (ctr 10). Two not-taken updates -> ctr 00, pred_pc_next=0x0011, hit=1.
- Alias: after 0x0010 allocation, pc_IF=0x0020 (same index, ENTRY_BITS=4) -> hit=0, next=0x0021. Taken update at 0x0020 target 0x0050 -> 0x0010 now misses.
- Saturation: three taken updates at 0x0040 target 0x0008, then one not-taken -> still taken (ctr 10), next=0x0008. Not-taken update at untrained 0x0070 -> no allocation, hit stays 0.
- Unconditional: upd_uncond=1 taken at 0x0005 target 0x0100 -> ctr 11; one not-taken update -> still predicts 0x0100.
- Same-cycle update + lookup at 0x0010 (taken, 0x0030): without BP_FWD_EN pred_taken=0 that cycle and 1 the next; with it pred_taken=1 immediately. Reset asserted with upd_valid=1 -> entry stays invalid.

Source files
------------

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped branch target buffer for the IF stage.
// Each entry holds valid, tag, target and a 2-bit saturating direction counter.
// Lookup on pc_IF is combinational. Training from the ID-stage resolver is
// registered on the rising edge of clk.
// Optional build macro BP_FWD_EN: when defined, a same-cycle update to the PC
// being fetched is bypassed onto the lookup outputs. When it is not defined,
// the outputs always come from registered state.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module branch_target_predictor #(
  parameter int ENTRY_BITS = 4,
  parameter int TAG_BITS   = `WORD_SIZE - ENTRY_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [`WORD_SIZE-1:0] pc_IF,
  output logic                  pred_taken,
  output logic                  pred_hit,
  output logic [`WORD_SIZE-1:0] pred_pc_next,
  input  logic                  upd_valid,
  input  logic [`WORD_SIZE-1:0] upd_pc,
  input  logic [`WORD_SIZE-1:0] upd_target,
  input  logic                  upd_taken,
  input  logic                  upd_uncond
);

  localparam int ENTRIES = 1 << ENTRY_BITS;
  localparam int W       = `WORD_SIZE;
  localparam logic [W-1:0] PC_INC = W'(1);

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [W-1:0]        target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [ENTRY_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  logic                  upd_we;
  logic                  nxt_valid;
  logic [TAG_BITS-1:0]   nxt_tag;
  logic [W-1:0]          nxt_target;
  logic [1:0]            nxt_ctr;

  logic [ENTRY_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag_pc;
  logic                  lk_valid;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [W-1:0]          lk_target;
  logic [1:0]            lk_ctr;

  assign upd_idx = upd_pc[ENTRY_BITS-1:0];
  assign upd_tag = upd_pc[W-1:ENTRY_BITS];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Next contents of the entry addressed by upd_pc. Defaults to the stored
  // entry, so a not-taken miss (no allocation) leaves everything unchanged.
  always_comb begin
    nxt_valid  = valid_q[upd_idx];
    nxt_tag    = tag_q[upd_idx];
    nxt_target = target_q[upd_idx];
    nxt_ctr    = ctr_q[upd_idx];
    upd_we     = 1'b0;
    if (upd_valid) begin
      if (!upd_hit) begin
        if (upd_taken) begin
          upd_we     = 1'b1;
          nxt_valid  = 1'b1;
          nxt_tag    = upd_tag;
          nxt_target = upd_target;
          nxt_ctr    = upd_uncond ? 2'b11 : 2'b10;
        end
      end else if (upd_taken) begin
        upd_we     = 1'b1;
        nxt_target = upd_target;
        if (upd_uncond || ctr_q[upd_idx] == 2'b11) nxt_ctr = 2'b11;
        else                                       nxt_ctr = ctr_q[upd_idx] + 2'd1;
      end else begin
        // An unconditional flag with taken=0 is meaningless, so it is trained
        // as an ordinary not-taken outcome.
        upd_we = 1'b1;
        if (ctr_q[upd_idx] == 2'b00) nxt_ctr = 2'b00;
        else                         nxt_ctr = ctr_q[upd_idx] - 2'd1;
      end
    end
  end

  // Table storage. Reset wins over any update presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_we) begin
      valid_q[upd_idx]  <= nxt_valid;
      tag_q[upd_idx]    <= nxt_tag;
      target_q[upd_idx] <= nxt_target;
      ctr_q[upd_idx]    <= nxt_ctr;
    end
  end

  assign lk_idx    = pc_IF[ENTRY_BITS-1:0];
  assign lk_tag_pc = pc_IF[W-1:ENTRY_BITS];

`ifdef BP_FWD_EN
  logic fwd_sel;
  assign fwd_sel = upd_valid && (upd_pc == pc_IF);

  // Lookup entry, with the in-flight update bypassed when it targets pc_IF.
  always_comb begin
    lk_valid  = fwd_sel ? nxt_valid  : valid_q[lk_idx];
    lk_tag    = fwd_sel ? nxt_tag    : tag_q[lk_idx];
    lk_target = fwd_sel ? nxt_target : target_q[lk_idx];
    lk_ctr    = fwd_sel ? nxt_ctr    : ctr_q[lk_idx];
  end
`else
  // Lookup entry straight from registered state.
  always_comb begin
    lk_valid  = valid_q[lk_idx];
    lk_tag    = tag_q[lk_idx];
    lk_target = target_q[lk_idx];
    lk_ctr    = ctr_q[lk_idx];
  end
`endif

  // Prediction outputs; fall-through wraps modulo the word size.
  always_comb begin
    pred_hit     = lk_valid && (lk_tag == lk_tag_pc);
    pred_taken   = pred_hit && lk_ctr[1];
    pred_pc_next = pred_taken ? lk_target : (pc_IF + PC_INC);
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: a table of update/lookup steps
// followed by hand-written same-cycle and reset sequences.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_IF;
  logic        pred_taken;
  logic        pred_hit;
  logic [15:0] pred_pc_next;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic        upd_uncond;

  int total = 0;
  int bad   = 0;

  branch_target_predictor dut (
    .clk          (clk),
    .reset        (reset),
    .pc_IF        (pc_IF),
    .pred_taken   (pred_taken),
    .pred_hit     (pred_hit),
    .pred_pc_next (pred_pc_next),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_taken    (upd_taken),
    .upd_uncond   (upd_uncond)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        do_upd;
    logic [15:0] u_pc;
    logic [15:0] u_tgt;
    logic        u_taken;
    logic        u_uncond;
    logic [15:0] look_pc;
    logic        e_hit;
    logic        e_taken;
    logic [15:0] e_next;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic du, input logic [15:0] up,
                     input logic [15:0] ut, input logic tk, input logic un,
                     input logic [15:0] lp, input logic eh, input logic et,
                     input logic [15:0] en);
    vec_t v;
    v.name = n; v.do_upd = du; v.u_pc = up; v.u_tgt = ut; v.u_taken = tk;
    v.u_uncond = un; v.look_pc = lp; v.e_hit = eh; v.e_taken = et; v.e_next = en;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic check_out(input string n, input logic eh, input logic et,
                           input logic [15:0] en);
    check({n, ".hit"},   {15'd0, pred_hit},   {15'd0, eh});
    check({n, ".taken"}, {15'd0, pred_taken}, {15'd0, et});
    check({n, ".next"},  pred_pc_next,        en);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    upd_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc_IF = 16'h0; upd_valid = 1'b0; upd_pc = 16'h0;
    upd_target = 16'h0; upd_taken = 1'b0; upd_uncond = 1'b0;

    //  name         upd  u_pc      u_tgt     tk  un  look      hit tk  next
    add("rst_0010",  0, 16'h0000, 16'h0000, 0, 0, 16'h0010, 0, 0, 16'h0011);
    add("rst_ffff",  0, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 0, 0, 16'h0000);
    add("alloc10",   1, 16'h0010, 16'h0030, 1, 0, 16'h0010, 1, 1, 16'h0030);
    add("nt_ctr01",  1, 16'h0010, 16'h0000, 0, 0, 16'h0010, 1, 0, 16'h0011);
    add("nt_ctr00",  1, 16'h0010, 16'h0000, 0, 0, 16'h0010, 1, 0, 16'h0011);
    add("nt_sat00",  1, 16'h0010, 16'h0000, 0, 0, 16'h0010, 1, 0, 16'h0011);
    add("t_ctr01",   1, 16'h0010, 16'h0030, 1, 0, 16'h0010, 1, 0, 16'h0011);
    add("t_ctr10",   1, 16'h0010, 16'h0030, 1, 0, 16'h0010, 1, 1, 16'h0030);
    add("idle_upd",  0, 16'h0020, 16'h0050, 1, 1, 16'h0020, 0, 0, 16'h0021);
    add("alias_ovr", 1, 16'h0020, 16'h0050, 1, 0, 16'h0010, 0, 0, 16'h0011);
    add("alias_new", 0, 16'h0000, 16'h0000, 0, 0, 16'h0020, 1, 1, 16'h0050);
    add("sat_t1",    1, 16'h0040, 16'h0008, 1, 0, 16'h0040, 1, 1, 16'h0008);
    add("sat_t2",    1, 16'h0040, 16'h0008, 1, 0, 16'h0040, 1, 1, 16'h0008);
    add("sat_t3",    1, 16'h0040, 16'h0008, 1, 0, 16'h0040, 1, 1, 16'h0008);
    add("sat_nt",    1, 16'h0040, 16'h0000, 0, 0, 16'h0040, 1, 1, 16'h0008);
    add("noalloc",   1, 16'h0070, 16'h0099, 0, 0, 16'h0070, 0, 0, 16'h0071);
    add("keep_0040", 0, 16'h0000, 16'h0000, 0, 0, 16'h0040, 1, 1, 16'h0008);
    add("unc_alloc", 1, 16'h0005, 16'h0100, 1, 1, 16'h0005, 1, 1, 16'h0100);
    add("unc_nt",    1, 16'h0005, 16'h0000, 0, 0, 16'h0005, 1, 1, 16'h0100);
    add("unc_as_nt", 1, 16'h0005, 16'h0000, 0, 1, 16'h0005, 1, 0, 16'h0006);
    add("unc_hit",   1, 16'h0005, 16'h0200, 1, 1, 16'h0005, 1, 1, 16'h0200);
    add("tgt_upd",   1, 16'h0005, 16'h0300, 1, 0, 16'h0005, 1, 1, 16'h0300);
    add("tag_miss",  0, 16'h0000, 16'h0000, 0, 0, 16'h0015, 0, 0, 16'h0016);
    add("top_alloc", 1, 16'hFFFF, 16'h1234, 1, 0, 16'hFFFF, 1, 1, 16'h1234);
    add("top_alias", 0, 16'h0000, 16'h0000, 0, 0, 16'h000F, 0, 0, 16'h0010);

    do_reset();

    foreach (vecs[i]) begin
      @(negedge clk);
      upd_valid  = vecs[i].do_upd;
      upd_pc     = vecs[i].u_pc;
      upd_target = vecs[i].u_tgt;
      upd_taken  = vecs[i].u_taken;
      upd_uncond = vecs[i].u_uncond;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      pc_IF     = vecs[i].look_pc;
      #1;
      check_out(vecs[i].name, vecs[i].e_hit, vecs[i].e_taken, vecs[i].e_next);
    end

    // Same-cycle update and lookup on a fresh table.
    do_reset();
    @(negedge clk);
    pc_IF = 16'h0010; upd_valid = 1'b1; upd_pc = 16'h0010;
    upd_target = 16'h0030; upd_taken = 1'b1; upd_uncond = 1'b0;
    #1;
`ifdef BP_FWD_EN
    check_out("same_cyc", 1'b1, 1'b1, 16'h0030);
`else
    check_out("same_cyc", 1'b0, 1'b0, 16'h0011);
`endif
    @(posedge clk);
    #1 upd_valid = 1'b0;
    #1 check_out("next_cyc", 1'b1, 1'b1, 16'h0030);

    // Reset asserted together with an update: the update must be dropped.
    @(negedge clk);
    reset = 1'b1; upd_valid = 1'b1; upd_pc = 16'h0040;
    upd_target = 16'h0077; upd_taken = 1'b1; upd_uncond = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; upd_valid = 1'b0;
    pc_IF = 16'h0040;
    #1 check_out("rst_drop", 1'b0, 1'b0, 16'h0041);
    pc_IF = 16'h0010;
    #1 check_out("rst_clear", 1'b0, 1'b0, 16'h0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
